// File: rtl/rib_rr_bus_pkg.sv
// Shared types and constants for the RIB round-robin bus.
// Bus-width names mirror the core's MemBus/MemAddrBus/HoldEnable set.
package rib_rr_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MEM_BUS      = 32;
  localparam int MEM_ADDR_BUS = 32;
  localparam int SIDX_HI      = 31;
  localparam int SIDX_LO      = 28;
  localparam int CNT_W        = 8;

  localparam logic [MEM_BUS-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [MEM_BUS-1:0] ERR_DATA  = ZERO_WORD;
  localparam logic [MEM_BUS-1:0] INST_NOP  = 32'h0000_0001;

  localparam logic HOLD_EN  = 1'b1;
  localparam logic HOLD_DIS = 1'b0;

  function automatic logic [3:0] slv_idx(
    input logic [MEM_ADDR_BUS-1:0] a
  );
    return a[SIDX_HI:SIDX_LO];
  endfunction

  function automatic logic [MEM_ADDR_BUS-1:0] slv_addr(
    input logic [MEM_ADDR_BUS-1:0] a
  );
    return {4'h0, a[SIDX_LO-1:0]};
  endfunction

endpackage

// File: rtl/rib_rr_bus_if.sv
// Master and slave side signal bundle of the RIB bus.
interface rib_rr_bus_if #(
  parameter int NUM_M = 4,
  parameter int NUM_S = 7
);
  import rib_rr_bus_pkg::*;

  logic [NUM_M*MEM_ADDR_BUS-1:0] m_addr_i;
  logic [NUM_M*MEM_BUS-1:0]      m_data_i;
  logic [NUM_M-1:0]              m_req_i;
  logic [NUM_M-1:0]              m_we_i;
  logic [NUM_M*MEM_BUS-1:0]      m_data_o;
  logic [NUM_M-1:0]              m_rsp_o;
  logic [NUM_M-1:0]              m_err_o;

  logic [NUM_S*MEM_ADDR_BUS-1:0] s_addr_o;
  logic [NUM_S*MEM_BUS-1:0]      s_data_o;
  logic [NUM_S-1:0]              s_req_o;
  logic [NUM_S-1:0]              s_we_o;
  logic [NUM_S-1:0]              s_ack_i;
  logic [NUM_S*MEM_BUS-1:0]      s_data_i;

  logic                          hold_flag_o;

  modport bus (
    input  m_addr_i, m_data_i, m_req_i, m_we_i,
    input  s_ack_i, s_data_i,
    output m_data_o, m_rsp_o, m_err_o,
    output s_addr_o, s_data_o, s_req_o, s_we_o,
    output hold_flag_o
  );

  modport master (
    output m_addr_i, m_data_i, m_req_i, m_we_i,
    input  m_data_o, m_rsp_o, m_err_o, hold_flag_o
  );

  modport slave (
    input  s_addr_o, s_data_o, s_req_o, s_we_o,
    output s_ack_i, s_data_i
  );

endinterface

// File: rtl/rib_rr_arbiter.sv
// Grant selection for the RIB bus: round-robin from rr_ptr,
// or fixed priority where the highest requesting index wins.
module rib_rr_arbiter
  import rib_rr_bus_pkg::*;
#(
  parameter int NUM_M  = 4,
  parameter int ARB_RR = 1,
  localparam int IW    = $clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req,
  input  logic             done,
  input  logic [IW-1:0]    done_idx,
  output logic [IW-1:0]    gnt
);

  logic [IW-1:0] rr_ptr;

  // Scan offsets downward so the requester closest to rr_ptr lands last.
  always_comb begin
    gnt = '0;
    if (ARB_RR != 0) begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        if (req[(int'(rr_ptr) + i) % NUM_M])
          gnt = IW'((int'(rr_ptr) + i) % NUM_M);
      end
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (req[i])
          gnt = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (ARB_RR != 0 && done) begin
      rr_ptr <= (done_idx == IW'(NUM_M - 1)) ?
                '0 : done_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rib_rr_bus.sv
// Multi-master / multi-slave RIB interconnect, one transfer in
// flight, with decode-miss and timeout error responses.
module rib_rr_bus
  import rib_rr_bus_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 7,
  parameter int ARB_RR  = 1,
  parameter int TIMEOUT = 16,
  parameter int NOP_M   = 1
) (
  input logic       clk,
  input logic       rst,
  rib_rr_bus_if.bus rib
);

  localparam int IW = $clog2(NUM_M);
  localparam int DW = MEM_BUS;
  localparam int AW = MEM_ADDR_BUS;
  localparam logic [NUM_M-1:0] NOP_MASK = NUM_M'(1) << NOP_M;

  state_t           state, state_nxt;
  logic [IW-1:0]    gnt_idx, gnt_nxt, arb_gnt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data, rdata;
  logic          g_we;
  logic [3:0]    sidx;
  logic          busy, hit, ack, tout, done;

  rib_rr_arbiter #(
    .NUM_M  (NUM_M),
    .ARB_RR (ARB_RR)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (rib.m_req_i),
    .done     (done),
    .done_idx (gnt_idx),
    .gnt      (arb_gnt)
  );

  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_we   = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (int'(gnt_idx) == m) begin
        g_addr = rib.m_addr_i[m*AW +: AW];
        g_data = rib.m_data_i[m*DW +: DW];
        g_we   = rib.m_we_i[m];
      end
    end
    busy = (state == BUSY);
    sidx = slv_idx(g_addr);
    hit  = busy && (int'(sidx) < NUM_S);

    ack          = 1'b0;
    rdata        = ZERO_WORD;
    rib.s_addr_o = '0;
    rib.s_data_o = '0;
    rib.s_req_o  = '0;
    rib.s_we_o   = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (hit && int'(sidx) == s) begin
        ack                    = rib.s_ack_i[s];
        rdata                  = rib.s_data_i[s*DW +: DW];
        rib.s_req_o[s]         = 1'b1;
        rib.s_we_o[s]          = g_we;
        rib.s_addr_o[s*AW +: AW] = slv_addr(g_addr);
        rib.s_data_o[s*DW +: DW] = g_data;
      end
    end

    // An ack on the last allowed cycle still counts as success.
    tout = busy && !ack &&
           (!hit || cnt == CNT_W'(TIMEOUT - 1));
    done = ack || tout;

    rib.m_rsp_o = '0;
    rib.m_err_o = '0;
    for (int m = 0; m < NUM_M; m++) begin
      rib.m_data_o[m*DW +: DW] = (m == NOP_M) ? INST_NOP : ZERO_WORD;
      if (done && int'(gnt_idx) == m) begin
        rib.m_rsp_o[m]           = 1'b1;
        rib.m_err_o[m]           = tout;
        rib.m_data_o[m*DW +: DW] = ack ? rdata : ERR_DATA;
      end
    end

    rib.hold_flag_o = (busy || |(rib.m_req_i & ~NOP_MASK)) ?
                      HOLD_EN : HOLD_DIS;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_idx;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (|rib.m_req_i) begin
          state_nxt = BUSY;
          gnt_nxt   = arb_gnt;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_idx <= gnt_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rib_rr_bus.sv
// Directed bench for rib_rr_bus: arbitration, latency, decode miss,
// timeout, reset abort and write routing.
module tb_rib_rr_bus;
  import rib_rr_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rib_rr_bus_if #(.NUM_M(4), .NUM_S(7)) b ();
  rib_rr_bus_if #(.NUM_M(4), .NUM_S(7)) bf ();

  rib_rr_bus dut (
    .clk (clk),
    .rst (rst),
    .rib (b)
  );

  rib_rr_bus #(.ARB_RR(0)) dut_f (
    .clk (clk),
    .rst (rst),
    .rib (bf)
  );

  assign bf.m_addr_i = b.m_addr_i;
  assign bf.m_data_i = b.m_data_i;
  assign bf.m_req_i  = b.m_req_i;
  assign bf.m_we_i   = b.m_we_i;
  assign bf.s_ack_i  = b.s_ack_i;
  assign bf.s_data_i = b.s_data_i;

  always #5 clk = ~clk;

  task automatic idle_inputs;
    b.m_addr_i = '0;
    b.m_data_i = '0;
    b.m_req_i  = '0;
    b.m_we_i   = '0;
    b.s_ack_i  = '0;
    b.s_data_i = '0;
  endtask

  task automatic set_m(input int k, input logic [31:0] a,
                       input logic [31:0] d, input logic we);
    b.m_addr_i[k*32 +: 32] = a;
    b.m_data_i[k*32 +: 32] = d;
    b.m_we_i[k]  = we;
    b.m_req_i[k] = 1'b1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (b.s_req_o !== 7'h0 || b.s_we_o !== 7'h0) begin
      errors++;
      $display("FAIL reset_sreq req=%b we=%b want 0", b.s_req_o, b.s_we_o);
    end
    checks++;
    if (b.m_rsp_o !== 4'h0 || b.m_err_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_mrsp rsp=%b err=%b want 0", b.m_rsp_o, b.m_err_o);
    end
    checks++;
    if (b.m_data_o[63:32] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_nop got %h want 00000001", b.m_data_o[63:32]);
    end
    checks++;
    if (b.m_data_o[31:0] !== 32'h0 || b.s_addr_o !== '0 || b.s_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data m0=%h saddr=%h want 0", b.m_data_o[31:0], b.s_addr_o);
    end
    checks++;
    if (b.hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want 0", b.hold_flag_o);
    end
    set_m(2, 32'h1000_0000, 32'h0, 1'b0);
    b.s_ack_i = '1;
    @(negedge clk); #1;
    checks++;
    if (b.m_rsp_o !== 4'h0 || b.s_req_o !== 7'h0) begin
      errors++;
      $display("FAIL reset_hold_req rsp=%b sreq=%b want 0", b.m_rsp_o, b.s_req_o);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_arbitration;
    int got_rr[$];
    int got_f[$];
    int exp_rr[6] = '{0, 2, 3, 0, 2, 3};
    int v;
    @(negedge clk);
    set_m(0, 32'h1000_0000, 32'h0, 1'b0);
    set_m(2, 32'h1000_0000, 32'h0, 1'b0);
    set_m(3, 32'h1000_0000, 32'h0, 1'b0);
    b.s_ack_i = '1;
    for (int c = 0; c < 20 && (got_rr.size() < 6 || got_f.size() < 3); c++) begin
      @(negedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (b.m_rsp_o[k])  got_rr.push_back(k);
        if (bf.m_rsp_o[k]) got_f.push_back(k);
      end
    end
    for (int i = 0; i < 6; i++) begin
      v = (i < got_rr.size()) ? got_rr[i] : -1;
      checks++;
      if (v != exp_rr[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %0d want %0d", i, v, exp_rr[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      v = (i < got_f.size()) ? got_f[i] : -1;
      checks++;
      if (v != 3) begin
        errors++;
        $display("FAIL fixed_grant[%0d] got %0d want 3", i, v);
      end
    end
    do_reset();
  endtask

  task automatic test_read_latency;
    @(negedge clk);
    set_m(1, 32'h1000_0040, 32'h0, 1'b0);
    #1;
    checks++;
    if (b.hold_flag_o !== 1'b0 || b.m_rsp_o !== 4'h0) begin
      errors++;
      $display("FAIL nop_idle hold=%b rsp=%b want 0 0", b.hold_flag_o, b.m_rsp_o);
    end
    @(negedge clk); #1;
    checks++;
    if (b.s_req_o !== 7'b0000010 || b.s_addr_o[63:32] !== 32'h0000_0040 ||
        b.s_we_o !== 7'h0) begin
      errors++;
      $display("FAIL rd_route req=%b addr=%h we=%b want 0000010 00000040 0",
               b.s_req_o, b.s_addr_o[63:32], b.s_we_o);
    end
    checks++;
    if (b.hold_flag_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold got %b want 1", b.hold_flag_o);
    end
    @(negedge clk);
    b.s_ack_i[4] = 1'b1;
    #1;
    checks++;
    if (b.m_rsp_o !== 4'h0) begin
      errors++;
      $display("FAIL stray_ack rsp=%b want 0000", b.m_rsp_o);
    end
    @(negedge clk);
    b.s_ack_i = 7'b0000010;
    b.s_data_i[63:32] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (b.m_rsp_o !== 4'b0010 || b.m_err_o !== 4'h0 ||
        b.m_data_o[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_rsp rsp=%b err=%b data=%h want 0010 0000 deadbeef",
               b.m_rsp_o, b.m_err_o, b.m_data_o[63:32]);
    end
    checks++;
    if (b.m_data_o[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL rd_other got %h want 0", b.m_data_o[31:0]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (b.s_req_o !== 7'h0 || b.m_rsp_o !== 4'h0) begin
      errors++;
      $display("FAIL rd_idle sreq=%b rsp=%b want 0", b.s_req_o, b.m_rsp_o);
    end
  endtask

  task automatic test_decode_miss;
    @(negedge clk);
    set_m(0, 32'hF000_0000, 32'h0, 1'b0);
    b.s_ack_i = '1;
    #1;
    checks++;
    if (b.m_rsp_o !== 4'h0) begin
      errors++;
      $display("FAIL miss_early rsp=%b want 0000", b.m_rsp_o);
    end
    @(negedge clk); #1;
    checks++;
    if (b.m_rsp_o !== 4'b0001 || b.m_err_o !== 4'b0001 ||
        b.m_data_o[31:0] !== 32'h0 || b.s_req_o !== 7'h0) begin
      errors++;
      $display("FAIL miss_rsp rsp=%b err=%b data=%h sreq=%b want 0001 0001 0 0",
               b.m_rsp_o, b.m_err_o, b.m_data_o[31:0], b.s_req_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout;
    int early = 0;
    @(negedge clk);
    set_m(2, 32'h4000_0000, 32'h0, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); #1;
      if (b.m_rsp_o !== 4'h0) early++;
      if (c == 1) begin
        checks++;
        if (b.s_req_o !== 7'b0010000) begin
          errors++;
          $display("FAIL to_route sreq=%b want 0010000", b.s_req_o);
        end
      end
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_early got %0d responses want 0", early);
    end
    @(negedge clk); #1;
    checks++;
    if (b.m_rsp_o !== 4'b0100 || b.m_err_o !== 4'b0100 ||
        b.m_data_o[95:64] !== 32'h0) begin
      errors++;
      $display("FAIL to_rsp rsp=%b err=%b data=%h want 0100 0100 0",
               b.m_rsp_o, b.m_err_o, b.m_data_o[95:64]);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (b.s_req_o !== 7'h0 || b.hold_flag_o !== 1'b0) begin
      errors++;
      $display("FAIL to_idle sreq=%b hold=%b want 0 0", b.s_req_o, b.hold_flag_o);
    end
    @(negedge clk);
    set_m(2, 32'h4000_0000, 32'h0, 1'b0);
    for (int c = 1; c <= 15; c++) @(negedge clk);
    @(negedge clk);
    b.s_ack_i[4] = 1'b1;
    b.s_data_i[4*32 +: 32] = 32'hA5A5_0004;
    #1;
    checks++;
    if (b.m_rsp_o !== 4'b0100 || b.m_err_o !== 4'h0 ||
        b.m_data_o[95:64] !== 32'hA5A5_0004) begin
      errors++;
      $display("FAIL to_ack_wins rsp=%b err=%b data=%h want 0100 0000 a5a50004",
               b.m_rsp_o, b.m_err_o, b.m_data_o[95:64]);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    @(negedge clk);
    set_m(0, 32'h1000_0000, 32'h0, 1'b0);
    b.s_ack_i = '1;
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    set_m(2, 32'h2000_0000, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (b.m_rsp_o !== 4'h0 || b.s_req_o !== 7'h0) begin
      errors++;
      $display("FAIL rst_busy rsp=%b sreq=%b want 0", b.m_rsp_o, b.s_req_o);
    end
    checks++;
    if (dut.state !== IDLE || dut.u_arb.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL rst_state state=%0d rr=%0d want 0 0",
               dut.state, dut.u_arb.rr_ptr);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    set_m(0, 32'h1000_0000, 32'h0, 1'b0);
    set_m(2, 32'h1000_0000, 32'h0, 1'b0);
    b.s_ack_i = '1;
    @(negedge clk); #1;
    checks++;
    if (b.m_rsp_o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_rr rsp=%b want 0001", b.m_rsp_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_write;
    @(negedge clk);
    set_m(3, 32'h2000_0008, 32'h1234_5678, 1'b1);
    #1;
    checks++;
    if (b.hold_flag_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_hold got %b want 1", b.hold_flag_o);
    end
    @(negedge clk);
    b.s_ack_i[2] = 1'b1;
    #1;
    checks++;
    if (b.s_we_o !== 7'b0000100 || b.s_data_o[95:64] !== 32'h1234_5678 ||
        b.s_addr_o[95:64] !== 32'h0000_0008) begin
      errors++;
      $display("FAIL wr_route we=%b data=%h addr=%h want 0000100 12345678 00000008",
               b.s_we_o, b.s_data_o[95:64], b.s_addr_o[95:64]);
    end
    checks++;
    if (b.m_data_o[63:32] !== 32'h0000_0001 || b.m_rsp_o !== 4'b1000 ||
        b.m_err_o !== 4'h0) begin
      errors++;
      $display("FAIL wr_rsp nop=%h rsp=%b err=%b want 00000001 1000 0000",
               b.m_data_o[63:32], b.m_rsp_o, b.m_err_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_arbitration();
    test_read_latency();
    test_decode_miss();
    test_timeout();
    test_reset_mid_busy();
    test_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
